lsu: RTL and testbench

Load/store unit for the RISC-V core's memory stage. Takes the ALU-computed address, store data and `func3` from execute, runs a request/grant/response transaction on the data-memory bus, and returns an aligned, sign/zero-extended load result for writeback. While a transaction is in flight it stalls the core. It also reports misaligned accesses and bus timeouts.

---
 rtl/lsu.sv | 156 +++++++++++++++
 tb/tb_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns execute-stage memory ops into a req/gnt/rvalid bus transaction,
// stalling the core while in flight and returning an aligned, extended load result.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [2:0]  lat_func3;
    logic [1:0]  lat_off;
    logic        illegal;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Width code lives in func3[1:0]; func3[2] is the unsigned flag, only meaningful for B/H loads.
    always_comb begin
        illegal = 1'b0;
        case (func3[1:0])
            2'b01:   illegal = addr[0];
            2'b10:   illegal = (addr[1:0] != 2'b00);
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
        if (func3[2] && (mem_we || func3[1]))
            illegal = 1'b1;
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (func3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    always_comb begin
        lane     = bus_rdata >> {lat_off, 3'b000};
        load_ext = bus_rdata;
        case (lat_func3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    assign timeout_hit = (cnt == CNT_LAST);

    // Grant beats timeout in REQ, rvalid beats timeout in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mem_req) state_next = illegal ? DONE : REQ;
            REQ: begin
                if (bus_gnt)          state_next = bus_we ? DONE : WAIT;
                else if (timeout_hit) state_next = DONE;
            end
            WAIT: if (bus_rvalid || timeout_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            lat_func3 <= 3'd0;
            lat_off   <= 2'd0;
            rdata     <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        misalign <= illegal;
                        bus_err  <= 1'b0;
                        if (!illegal) begin
                            cnt       <= 8'd0;
                            lat_func3 <= func3;
                            lat_off   <= addr[1:0];
                            bus_we    <= mem_we;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_calc;
                            bus_wdata <= wdata_calc;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (!bus_gnt && timeout_hit)
                        bus_err <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus_rvalid)
                        rdata <= load_ext;
                    else if (timeout_hit)
                        bus_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done    = (state == DONE);
    assign bus_req = (state == REQ);
    assign stall   = !rst && ((state == REQ) || (state == WAIT) || ((state == IDLE) && mem_req));

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: each access pushes its expected outcome to a scoreboard,
// which is popped and compared when done pulses.
module tb_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        int          done_cycle;
        int          req_cycles;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
    } exp_t;

    exp_t sb[$];

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .func3(func3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rd, input logic mis, input logic berr,
                                input int dc, input int rc, input logic [31:0] ba,
                                input logic [3:0] be, input logic [31:0] bw);
        exp_t e;
        e.rdata = rd; e.mis = mis; e.berr = berr; e.done_cycle = dc;
        e.req_cycles = rc; e.baddr = ba; e.be = be; e.bwdata = bw;
        return e;
    endfunction

    // gnt_lat: extra REQ cycles before grant (-1 = never); rv_lat: cycles after grant until rvalid (0 = never)
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int gnt_lat, input int rv_lat, input logic [31:0] rd,
                                 input exp_t e);
        int   k = 0;
        int   req_cycles = 0;
        int   since_gnt = 0;
        bit   granted = 0;
        bit   seen_done = 0;
        sb.push_back(e);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; func3 = f3; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1 check({tag, " stall C0"}, 32'(stall), 32'd1);
        while (!seen_done && k < 40) begin
            @(negedge clk);
            k++;
            mem_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
            if (granted) begin
                since_gnt++;
                if (rv_lat > 0 && since_gnt == rv_lat) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd;
                end
            end
            if (bus_req) begin
                if (req_cycles == 0) begin
                    check({tag, " bus_addr"},  bus_addr,  e.baddr);
                    check({tag, " bus_be"},    32'(bus_be), 32'(e.be));
                    check({tag, " bus_wdata"}, bus_wdata, e.bwdata);
                    check({tag, " bus_we"},    32'(bus_we), 32'(we));
                end
                if (gnt_lat >= 0 && req_cycles == gnt_lat) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                end
                req_cycles++;
            end
            #1;
            if (done) begin
                exp_t x;
                seen_done = 1;
                x = sb.pop_front();
                check({tag, " done cycle"}, 32'(k), 32'(x.done_cycle));
                check({tag, " req cycles"}, 32'(req_cycles), 32'(x.req_cycles));
                check({tag, " rdata"},    rdata, x.rdata);
                check({tag, " misalign"}, 32'(misalign), 32'(x.mis));
                check({tag, " bus_err"},  32'(bus_err), 32'(x.berr));
                // mem_req during DONE belongs to the retiring op and must be ignored
                mem_req = 1'b1; mem_we = 1'b1; func3 = 3'b111;
                #1 check({tag, " stall in DONE"}, 32'(stall), 32'd0);
            end else begin
                check({tag, " stall busy"}, 32'(stall), 32'd1);
            end
        end
        if (!seen_done) begin
            check({tag, " done seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        check({tag, " no reissue done"}, 32'(done), 32'd0);
        check({tag, " no reissue stall"}, 32'(stall), 32'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_rdata);
        check({tag, " done idle"}, 32'(done), 32'd0);
        check({tag, " rdata held"}, rdata, exp_rdata);
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; func3 = 3'b010; addr = 32'h0; wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset misalign", 32'(misalign), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_be", 32'(bus_be), 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        rst = 1'b0; mem_req = 1'b0;

        applyStimulus("SW", 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0,
                      mk(32'h0, 1'b0, 1'b0, 2, 1, 32'h104, 4'b1111, 32'hDEAD_BEEF));
        applyStimulus("SB", 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,
                      mk(32'h0, 1'b0, 1'b0, 2, 1, 32'h200, 4'b1000, 32'hA5A5_A5A5));
        applyStimulus("LB", 1'b0, 3'b000, 32'h0000_0302, 32'h0, 0, 1, 32'h1280_3456,
                      mk(32'hFFFF_FF80, 1'b0, 1'b0, 3, 1, 32'h300, 4'b0100, 32'h0));
        applyStimulus("LBU", 1'b0, 3'b100, 32'h0000_0302, 32'h0, 0, 1, 32'h1280_3456,
                      mk(32'h0000_0080, 1'b0, 1'b0, 3, 1, 32'h300, 4'b0100, 32'h0));
        applyStimulus("LH", 1'b0, 3'b001, 32'h0000_0302, 32'h0, 0, 1, 32'h1280_3456,
                      mk(32'h0000_1280, 1'b0, 1'b0, 3, 1, 32'h300, 4'b1100, 32'h0));
        applyStimulus("LW misaligned", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 1, 32'h0,
                      mk(32'h0000_1280, 1'b1, 1'b0, 1, 0, 32'h0, 4'b0, 32'h0));
        applyStimulus("LW timeout", 1'b0, 3'b010, 32'h0000_0400, 32'h1111_2222, -1, 0, 32'h0,
                      mk(32'h0000_1280, 1'b0, 1'b1, 5, 4, 32'h400, 4'b1111, 32'h1111_2222));

        // rvalid arriving after the abort is ignored
        @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk); bus_rvalid = 1'b0;
        #1 checkOutput("late rvalid", 32'h0000_1280);
        check("late rvalid bus_err held", 32'(bus_err), 32'd1);

        applyStimulus("LHU slow gnt", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 1, 1, 32'hBEEF_1234,
                      mk(32'h0000_BEEF, 1'b0, 1'b0, 4, 2, 32'h0, 4'b1100, 32'h0));
        applyStimulus("store func3 100", 1'b1, 3'b100, 32'h0000_0010, 32'h0, 0, 0, 32'h0,
                      mk(32'h0000_BEEF, 1'b1, 1'b0, 1, 0, 32'h0, 4'b0, 32'h0));
        applyStimulus("SH", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 0, 0, 32'h0,
                      mk(32'h0000_BEEF, 1'b0, 1'b0, 2, 1, 32'h4, 4'b1100, 32'hABCD_ABCD));

        // reset while waiting for read data abandons the load
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0500;
        @(negedge clk);
        mem_req = 1'b0; bus_gnt = 1'b1;
        #1 check("rst-wait bus_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        bus_gnt = 1'b0;
        #1 check("rst-wait stall in WAIT", 32'(stall), 32'd1);
        rst = 1'b1;
        #1 check("rst-wait stall gated", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst-wait bus_req after", 32'(bus_req), 32'd0);
        check("rst-wait stall after", 32'(stall), 32'd0);
        checkOutput("rst-wait", 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("rst-wait no done", 32'(done), 32'd0);
        end

        applyStimulus("SW after reset", 1'b1, 3'b010, 32'h0000_0008, 32'h0BAD_F00D, 0, 0, 32'h0,
                      mk(32'h0, 1'b0, 1'b0, 2, 1, 32'h8, 4'b1111, 32'h0BAD_F00D));

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
